ras_ctrl: RTL and testbench
===========================

RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 Parameter DEPTH, default 16, number of return-address entries (power of two, 4..64).
REQ-002 Parameter WIDTH, default 32, address width.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 if_valid  input  1  fetch slot holds a valid predecoded instruction.
REQ-006 if_stall  input  1  fetch held; slot not accepted this cycle.
REQ-007 if_pc  input  WIDTH  PC of the fetch-slot instruction.
REQ-008 if_is_call  input  1  predecode: call (jal/jalr with rd=x1/x5).
REQ-009 if_is_ret  input  1  predecode: return (jalr rs1=x1/x5, rd=x0).
REQ-010 wb_valid  input  1  instruction retiring this cycle.
REQ-011 wb_is_call  input  1  retiring instruction is a call.
REQ-012 wb_is_ret  input  1  retiring instruction is a return.
REQ-013 flush  input  1  pipeline redirect; discard speculative RAS state.
REQ-014 pred_valid  output  1  pred_target usable as the next-fetch PC.
REQ-015 pred_target  output  WIDTH  predicted return address.
REQ-016 ras_empty  output  1  speculative occupancy is zero.

Function
REQ-017 Fetch slot accepted when if_valid & ~if_stall & ~flush & state==RUN; no speculative update otherwise.
REQ-018 Accepted call: write if_pc+4 (modulo 2^WIDTH) at spec_ptr; spec_ptr+1 modulo DEPTH; spec_cnt+1 saturating at DEPTH.
REQ-019 Accepted return with spec_cnt>0: spec_ptr-1 modulo DEPTH, spec_cnt-1; with spec_cnt==0: no change.
REQ-020 Full stack + call: oldest entry overwritten (circular), spec_cnt stays DEPTH.
REQ-021 pred_valid combinational = if_valid & if_is_ret & spec_cnt!=0 & state==RUN; pred_target = entry[spec_ptr-1]; pred_target=0 when pred_valid=0.
REQ-022 Retire path maintains commit_ptr/commit_cnt under the same rules as REQ-018..020, gated by wb_valid; entries are not written by retire.
REQ-023 FSM states RUN, RECOVER; RUN->RECOVER on flush; RECOVER->RUN unconditionally after one cycle.
REQ-024 On flush: spec_ptr/spec_cnt load the commit values including any same-cycle retire update; fetch-slot update that cycle discarded.
REQ-025 In RECOVER: pred_valid=0, no speculative updates; retire updates continue.
REQ-026 Call and return in the same slot without RAS_COROUTINE_EN: treated as return only.
REQ-027 ras_empty = (spec_cnt==0), registered-state derived, no combinational input path.

Reset
REQ-028 rst_n low asynchronously clears spec_ptr, spec_cnt, commit_ptr, commit_cnt to 0, all entries to 0, state to RUN; pred_valid=0, pred_target=0, ras_empty=1 while asserted.
REQ-029 Reset asserted mid-recovery or mid-push discards the operation; first cycle after deassertion behaves as empty RUN.

Configuration
REQ-030 Macro RAS_COROUTINE_EN defined: call+return in one slot (fetch or retire) replaces top entry with pc+4, pointer and count unchanged (count 0: acts as push); prediction still uses pre-replacement top; undefined: REQ-026 applies.

Structure
REQ-031 Package ras_pkg holds ras_state_e (RUN, RECOVER), DEPTH/WIDTH defaults, and the pointer-width constant $clog2(DEPTH).
REQ-032 Sub-module ras_stack: DEPTH x WIDTH circular storage, one write port, one async read port; ras_ctrl owns all pointers, counts and FSM.

Verification
REQ-033 Reset, calls at 0x100, 0x200, 0x300, then return -> pred_target=0x304, pred_valid=1; next return -> 0x204.
REQ-034 17 calls at 0x1000+16*i, i=0..16, DEPTH=16 -> spec_cnt=16; 16 returns predict 0x1104 down to 0x1014; 17th return pred_valid=0.
REQ-035 Calls 0x100,0x200 retired, then speculative call 0x300 and return, flush -> one cycle pred_valid=0, then return predicts 0x204.
REQ-036 Return on empty stack -> pred_valid=0, spec_cnt stays 0, ras_empty=1.
REQ-037 Call 0x400 with if_stall=1 for 3 cycles then released -> exactly one push, spec_cnt=1.
REQ-038 RAS_COROUTINE_EN, top 0x104, call+return at 0x500 -> pred_target=0x104, new top 0x504, spec_cnt unchanged.

Source files
------------

// File: rtl/ras_pkg.sv
// Shared types and defaults for the return-address-stack predictor.
// RAS_COROUTINE_EN: a call+return in one slot replaces the top entry instead of popping.
package ras_pkg;

  localparam int unsigned DefaultDepth = 16;
  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultPtrW  = $clog2(DefaultDepth);

`ifdef RAS_COROUTINE_EN
  localparam bit CoroutineEn = 1'b1;
`else
  localparam bit CoroutineEn = 1'b0;
`endif

  typedef enum logic [0:0] {RUN, RECOVER} ras_state_e;

  typedef enum logic [1:0] {OpNone, OpPush, OpPop, OpRepl} ras_op_e;

  // Call+return collapses to a pop unless coroutine replacement is enabled.
  function automatic ras_op_e ras_decode(input logic is_call, input logic is_ret);
    ras_op_e op;
    op = OpNone;
    if (is_call) op = OpPush;
    if (is_ret) op = (CoroutineEn && is_call) ? OpRepl : OpPop;
    return op;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address storage: one synchronous write port, one asynchronous read port.
module ras_stack import ras_pkg::*; #(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned PTR_W = DefaultPtrW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: speculative and committed pointers plus flush recovery.
// RAS_COROUTINE_EN (see ras_pkg) selects replace-top behaviour for call+return slots.
module ras_ctrl import ras_pkg::*; #(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic             if_stall,
  input  logic [WIDTH-1:0] if_pc,
  input  logic             if_is_call,
  input  logic             if_is_ret,
  input  logic             wb_valid,
  input  logic             wb_is_call,
  input  logic             wb_is_ret,
  input  logic             flush,
  output logic             pred_valid,
  output logic [WIDTH-1:0] pred_target,
  output logic             ras_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

  typedef struct packed {
    logic [PtrW-1:0] ptr;
    logic [CntW-1:0] cnt;
  } pos_t;

  // Pointer wraps naturally at DEPTH; count saturates so a full push overwrites the oldest.
  function automatic pos_t step(input ras_op_e op, input pos_t cur);
    pos_t nxt;
    nxt = cur;
    case (op)
      OpPush: begin
        nxt.ptr = cur.ptr + PtrW'(1);
        if (cur.cnt != CntMax) nxt.cnt = cur.cnt + CntW'(1);
      end
      OpPop: begin
        if (cur.cnt != '0) begin
          nxt.ptr = cur.ptr - PtrW'(1);
          nxt.cnt = cur.cnt - CntW'(1);
        end
      end
      OpRepl: begin
        if (cur.cnt == '0) begin
          nxt.ptr = cur.ptr + PtrW'(1);
          nxt.cnt = cur.cnt + CntW'(1);
        end
      end
      default: ;
    endcase
    return nxt;
  endfunction

  ras_state_e state_q, state_d;
  pos_t spec_q, spec_d, commit_q, commit_d;
  ras_op_e if_op, wb_op;
  logic run, accept, we;
  logic [PtrW-1:0] waddr, top_idx;
  logic [WIDTH-1:0] top_data;

  assign run     = (state_q == RUN);
  assign accept  = if_valid & ~if_stall & ~flush & run;
  assign if_op   = ras_decode(if_is_call, if_is_ret);
  assign wb_op   = ras_decode(wb_is_call, wb_is_ret);
  assign top_idx = spec_q.ptr - PtrW'(1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush) state_d = RECOVER;
      RECOVER: state_d = RUN;
      default: state_d = RUN;
    endcase

    commit_d = wb_valid ? step(wb_op, commit_q) : commit_q;

    // Flush restores the committed view, including a retire landing in the same cycle.
    spec_d = spec_q;
    if (flush) spec_d = commit_d;
    else if (accept) spec_d = step(if_op, spec_q);

    we    = accept && (if_op == OpPush || if_op == OpRepl);
    waddr = (if_op == OpRepl && spec_q.cnt != '0) ? top_idx : spec_q.ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      spec_q   <= '0;
      commit_q <= '0;
    end else begin
      state_q  <= state_d;
      spec_q   <= spec_d;
      commit_q <= commit_d;
    end
  end

  ras_stack #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .PTR_W (PtrW)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (if_pc + WIDTH'(4)),
    .raddr (top_idx),
    .rdata (top_data)
  );

  assign pred_valid  = if_valid & if_is_ret & (spec_q.cnt != '0) & run;
  assign pred_target = pred_valid ? top_data : '0;
  assign ras_empty   = (spec_q.cnt == '0);

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed self-checking bench for ras_ctrl (DEPTH=16, WIDTH=32).
module tb_ras_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, if_stall, if_is_call, if_is_ret;
  logic [31:0] if_pc;
  logic        wb_valid, wb_is_call, wb_is_ret, flush;
  logic        pred_valid, ras_empty;
  logic [31:0] pred_target;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ras_ctrl #(
    .DEPTH (16),
    .WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_valid    (if_valid),
    .if_stall    (if_stall),
    .if_pc       (if_pc),
    .if_is_call  (if_is_call),
    .if_is_ret   (if_is_ret),
    .wb_valid    (wb_valid),
    .wb_is_call  (wb_is_call),
    .wb_is_ret   (wb_is_ret),
    .flush       (flush),
    .pred_valid  (pred_valid),
    .pred_target (pred_target),
    .ras_empty   (ras_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    if_valid = 0; if_stall = 0; if_pc = '0; if_is_call = 0; if_is_ret = 0;
    wb_valid = 0; wb_is_call = 0; wb_is_ret = 0; flush = 0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic call, input logic ret);
    if_valid = 1; if_pc = pc; if_is_call = call; if_is_ret = ret;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic pred(input string tag, input logic pv, input logic [31:0] tgt);
    #1;
    chk({tag, ".pv"}, 32'(pred_valid), 32'(pv));
    chk({tag, ".tgt"}, pred_target, tgt);
  endtask

  task automatic do_call(input logic [31:0] pc);
    fetch(pc, 1, 0);
    tick();
  endtask

  task automatic do_ret(input string tag, input logic pv, input logic [31:0] tgt);
    fetch(32'h0000_8000, 0, 1);
    pred(tag, pv, tgt);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    idle();
    rst_n = 0;
    fetch(32'h0, 0, 1);
    pred("reset", 0, 0);
    chk("reset.empty", 32'(ras_empty), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    idle();

    // Basic nesting
    do_call(32'h100); do_call(32'h200); do_call(32'h300);
    chk("three_calls.empty", 32'(ras_empty), 0);
    do_ret("ret1", 1, 32'h304);
    do_ret("ret2", 1, 32'h204);
    do_ret("ret3", 1, 32'h104);
    chk("drained.empty", 32'(ras_empty), 1);
    do_ret("empty_ret", 0, 0);
    chk("empty_ret.empty", 32'(ras_empty), 1);

    // Return address wraps modulo 2^WIDTH
    do_call(32'hFFFF_FFFC);
    do_ret("wrap", 1, 32'h0);

    // Stalled call is pushed exactly once on release
    repeat (3) begin
      fetch(32'h400, 1, 0);
      if_stall = 1;
      tick();
    end
    chk("stall_hold.empty", 32'(ras_empty), 1);
    do_call(32'h400);
    chk("stall_rel.empty", 32'(ras_empty), 0);
    do_ret("stall_ret", 1, 32'h404);
    chk("stall_once.empty", 32'(ras_empty), 1);

    // Overflow: 17 calls into 16 entries, oldest lost
    for (int i = 0; i <= 16; i++) do_call(32'h1000 + 32'(16 * i));
    for (int k = 16; k >= 1; k--) do_ret($sformatf("deep%0d", k), 1, 32'h1004 + 32'(16 * k));
    do_ret("deep_under", 0, 0);
    chk("deep_under.empty", 32'(ras_empty), 1);

    // Reset asserted mid-push discards everything
    do_call(32'h700);
    fetch(32'h710, 1, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_mid.empty", 32'(ras_empty), 1);
    @(posedge clk);
    #1;
    rst_n = 1;
    idle();
    do_ret("post_rst", 0, 0);

    // Flush recovery to committed state, with a retire in the flush cycle
    do_call(32'h100);
    fetch(32'h200, 1, 0); wb_valid = 1; wb_is_call = 1; tick();
    do_call(32'h300);
    do_ret("spec_ret", 1, 32'h304);
    do_call(32'h380);
    fetch(32'h900, 1, 0); flush = 1; wb_valid = 1; wb_is_call = 1; tick();
    fetch(32'h0, 0, 1);
    pred("recover", 0, 0);
    tick();
    do_ret("after_flush", 1, 32'h204);
    do_ret("after_flush2", 1, 32'h104);
    chk("after_flush.empty", 32'(ras_empty), 1);

    // Call and return in one slot
    do_call(32'h100);
    fetch(32'h500, 1, 1);
    pred("coro", 1, 32'h104);
    tick();
`ifdef RAS_COROUTINE_EN
    chk("coro.empty", 32'(ras_empty), 0);
    do_ret("coro_top", 1, 32'h504);
    chk("coro_top.empty", 32'(ras_empty), 1);
`else
    chk("coro.empty", 32'(ras_empty), 1);
    do_ret("coro_ret_only", 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
